silife_frame_snapshot: RTL and testbench



---
 rtl/silife_frame_snapshot.sv | 164 ++++++++++++++++
 tb/tb_silife_frame_snapshot.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/silife_frame_snapshot.sv
// silife_frame_snapshot: double-buffered row store between the Life grid
// engine and the MAX7219 display driver. After each generation all rows
// are copied into the back bank, which is then swapped to the front.
// Optional macro SILIFE_SNAPSHOT_SKIP_UNCHANGED_EN suppresses the swap
// and frame pulse when the new generation matches the front bank.
module silife_frame_snapshot #(
  parameter int WIDTH  = 32,
  parameter int HEIGHT = 32,
  localparam int ROW_BITS = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_enable,
  input  logic                i_generation_done,
  output logic [ROW_BITS-1:0] o_grid_row_select,
  input  logic [WIDTH-1:0]    i_grid_cells,
  input  logic [ROW_BITS-1:0] i_row_select,
  output logic [WIDTH-1:0]    o_cells,
  input  logic                i_display_busy,
  output logic                o_frame,
  output logic                o_valid,
  output logic                o_busy,
  output logic                o_overrun
);

  localparam int CNT_BITS = ROW_BITS + 1;
  localparam logic [CNT_BITS-1:0] CNT_LAST     = CNT_BITS'(HEIGHT);
  localparam logic [CNT_BITS-1:0] CNT_LAST_ROW = CNT_BITS'(HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, SWAP} state_t;

  state_t                state_q, state_d;
  logic                  bank_sel_q, bank_sel_d;
  logic                  valid_q, valid_d;
  logic                  frame_q, frame_d;
  logic                  overrun_q, overrun_d;
  logic [ROW_BITS-1:0]   row_sel_q, row_sel_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic [CNT_BITS-1:0]   cnt_inc, cnt_dec;
  logic                  wr_en;
  logic [ROW_BITS-1:0]   wr_row;
`ifdef SILIFE_SNAPSHOT_SKIP_UNCHANGED_EN
  logic                  diff_q, diff_d;
`endif

  // Bank storage; index 0/1, bank_sel_q names the front bank. Not reset.
  logic [WIDTH-1:0] mem [0:1][0:HEIGHT-1];

  assign cnt_inc = cnt_q + 1'b1;
  assign cnt_dec = cnt_q - 1'b1;
  // Data arriving in capture cycle c belongs to the row selected in c-1.
  assign wr_row  = cnt_dec[ROW_BITS-1:0];

  // Next-state logic for the capture/swap sequencer.
  always_comb begin
    state_d    = state_q;
    bank_sel_d = bank_sel_q;
    valid_d    = valid_q;
    frame_d    = 1'b0;
    overrun_d  = 1'b0;
    row_sel_d  = row_sel_q;
    cnt_d      = cnt_q;
    wr_en      = 1'b0;
`ifdef SILIFE_SNAPSHOT_SKIP_UNCHANGED_EN
    diff_d     = diff_q;
`endif
    if (!i_enable) begin
      // Abort: partial back bank is simply abandoned, front stays shown.
      state_d   = IDLE;
      cnt_d     = '0;
      row_sel_d = '0;
    end else begin
      if (i_generation_done && state_q != IDLE) overrun_d = 1'b1;
      case (state_q)
        IDLE: begin
          if (i_generation_done) begin
            state_d   = CAPTURE;
            cnt_d     = '0;
            row_sel_d = '0;
`ifdef SILIFE_SNAPSHOT_SKIP_UNCHANGED_EN
            diff_d    = 1'b0;
`endif
          end
        end
        CAPTURE: begin
          if (cnt_q != '0) begin
            wr_en = 1'b1;
`ifdef SILIFE_SNAPSHOT_SKIP_UNCHANGED_EN
            if (i_grid_cells != mem[bank_sel_q][wr_row]) diff_d = 1'b1;
`endif
          end
          if (cnt_q == CNT_LAST) begin
            state_d   = SWAP;
            cnt_d     = '0;
            row_sel_d = '0;
          end else begin
            cnt_d     = cnt_inc;
            row_sel_d = (cnt_q < CNT_LAST_ROW) ? cnt_inc[ROW_BITS-1:0] : '0;
          end
        end
        SWAP: begin
`ifdef SILIFE_SNAPSHOT_SKIP_UNCHANGED_EN
          if (valid_q && !diff_q) begin
            state_d = IDLE;
          end else
`endif
          if (!i_display_busy) begin
            bank_sel_d = ~bank_sel_q;
            valid_d    = 1'b1;
            frame_d    = 1'b1;
            state_d    = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bank_sel_q <= 1'b0;
      valid_q    <= 1'b0;
      frame_q    <= 1'b0;
      overrun_q  <= 1'b0;
      row_sel_q  <= '0;
      cnt_q      <= '0;
`ifdef SILIFE_SNAPSHOT_SKIP_UNCHANGED_EN
      diff_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      bank_sel_q <= bank_sel_d;
      valid_q    <= valid_d;
      frame_q    <= frame_d;
      overrun_q  <= overrun_d;
      row_sel_q  <= row_sel_d;
      cnt_q      <= cnt_d;
`ifdef SILIFE_SNAPSHOT_SKIP_UNCHANGED_EN
      diff_q     <= diff_d;
`endif
    end
  end

  // Back-bank row write during capture.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem[~bank_sel_q][wr_row] <= i_grid_cells;
  end

  // Front-bank read port; out-of-range rows read as zero.
  always_comb begin
    o_cells = '0;
    if (valid_q && ({1'b0, i_row_select} < CNT_LAST))
      o_cells = mem[bank_sel_q][i_row_select];
  end

  assign o_grid_row_select = row_sel_q;
  assign o_frame           = frame_q;
  assign o_valid           = valid_q;
  assign o_overrun         = overrun_q;
  assign o_busy            = (state_q != IDLE);

endmodule

// File: tb/tb_silife_frame_snapshot.sv
// Directed bench for silife_frame_snapshot (WIDTH=HEIGHT=32).
// The engine model returns (32'h01010101*row)^mask one cycle after the
// row select; each test uses a different mask so frames are distinguishable.
module tb_silife_frame_snapshot;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_enable = 1'b1;
  logic        i_generation_done = 1'b0;
  logic [4:0]  o_grid_row_select;
  logic [31:0] i_grid_cells = '0;
  logic [4:0]  i_row_select = 5'd5;
  logic [31:0] o_cells;
  logic        i_display_busy = 1'b0;
  logic        o_frame, o_valid, o_busy, o_overrun;

  int          n_vec = 0;
  int          n_err = 0;
  int          frames = 0;
  int          f0;
  logic [31:0] mask = '0;

  silife_frame_snapshot #(.WIDTH(32), .HEIGHT(32)) dut (
    .clk(clk), .reset(reset), .i_enable(i_enable),
    .i_generation_done(i_generation_done),
    .o_grid_row_select(o_grid_row_select), .i_grid_cells(i_grid_cells),
    .i_row_select(i_row_select), .o_cells(o_cells),
    .i_display_busy(i_display_busy), .o_frame(o_frame), .o_valid(o_valid),
    .o_busy(o_busy), .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  // Engine read port: one cycle latency.
  always @(posedge clk) i_grid_cells <= (32'h01010101 * {27'd0, o_grid_row_select}) ^ mask;

  // Frame pulse counter.
  always @(posedge clk) if (o_frame === 1'b1) frames <= frames + 1;

  function automatic logic [31:0] pat(int k, logic [31:0] m);
    return (32'h01010101 * k) ^ m;
  endfunction

  task automatic cycles(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulse generation_done in the current cycle T; returns in cycle T+1.
  task automatic gen_pulse();
    i_generation_done = 1'b1;
    cycles(1);
    i_generation_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycles(3);
    reset = 1'b0;
    cycles(1);
    n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %0b want 0", o_valid); end
    n_vec++; if (o_frame !== 1'b0) begin n_err++; $display("FAIL rst_frame got %0b want 0", o_frame); end
    n_vec++; if (o_overrun !== 1'b0) begin n_err++; $display("FAIL rst_overrun got %0b want 0", o_overrun); end
    n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %0b want 0", o_busy); end
    n_vec++; if (o_grid_row_select !== 5'd0) begin n_err++; $display("FAIL rst_rowsel got %0d want 0", o_grid_row_select); end
    n_vec++; if (o_cells !== 32'h0) begin n_err++; $display("FAIL rst_cells got %h want 0", o_cells); end
  endtask

  task automatic test_capture();
    mask = 32'h0;
    i_row_select = 5'd5;
    gen_pulse();                                   // T+1
    n_vec++; if (o_grid_row_select !== 5'd0) begin n_err++; $display("FAIL cap_row0 got %0d want 0", o_grid_row_select); end
    n_vec++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL cap_busy got %0b want 1", o_busy); end
    cycles(4);                                     // T+5
    n_vec++; if (o_grid_row_select !== 5'd4) begin n_err++; $display("FAIL cap_row4 got %0d want 4", o_grid_row_select); end
    cycles(27);                                    // T+32
    n_vec++; if (o_grid_row_select !== 5'd31) begin n_err++; $display("FAIL cap_row31 got %0d want 31", o_grid_row_select); end
    cycles(1);                                     // T+33
    n_vec++; if (o_grid_row_select !== 5'd0) begin n_err++; $display("FAIL cap_rowret got %0d want 0", o_grid_row_select); end
    cycles(1);                                     // T+34
    n_vec++; if (o_frame !== 1'b0) begin n_err++; $display("FAIL cap_early_frame got %0b want 0", o_frame); end
    n_vec++; if (o_cells !== 32'h0) begin n_err++; $display("FAIL cap_preswap_cells got %h want 0", o_cells); end
    cycles(1);                                     // T+35
    n_vec++; if (o_frame !== 1'b1) begin n_err++; $display("FAIL cap_frame got %0b want 1", o_frame); end
    n_vec++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL cap_valid got %0b want 1", o_valid); end
    n_vec++; if (o_cells !== pat(5, mask)) begin n_err++; $display("FAIL cap_row5 got %h want %h", o_cells, pat(5, mask)); end
    i_row_select = 5'd31; #1;
    n_vec++; if (o_cells !== pat(31, mask)) begin n_err++; $display("FAIL cap_rowlast got %h want %h", o_cells, pat(31, mask)); end
    i_row_select = 5'd0; #1;
    n_vec++; if (o_cells !== 32'h0) begin n_err++; $display("FAIL cap_rowfirst got %h want 0", o_cells); end
    i_row_select = 5'd5;
    cycles(1);                                     // T+36
    n_vec++; if (o_frame !== 1'b0) begin n_err++; $display("FAIL cap_frame_width got %0b want 0", o_frame); end
    n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL cap_idle got %0b want 0", o_busy); end
  endtask

  task automatic test_display_busy();
    mask = 32'hA0A0A0A0;
    i_display_busy = 1'b1;
    f0 = frames;
    gen_pulse();                                   // T+1
    cycles(48);                                    // T+49
    n_vec++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL busy_pending got %0b want 1", o_busy); end
    n_vec++; if (o_cells !== pat(5, 32'h0)) begin n_err++; $display("FAIL busy_oldcells got %h want %h", o_cells, pat(5, 32'h0)); end
    cycles(1);                                     // T+50
    i_display_busy = 1'b0;
    #1;
    n_vec++; if (o_frame !== 1'b0) begin n_err++; $display("FAIL busy_noframe got %0b want 0", o_frame); end
    n_vec++; if (o_cells !== pat(5, 32'h0)) begin n_err++; $display("FAIL busy_oldcells2 got %h want %h", o_cells, pat(5, 32'h0)); end
    cycles(1);                                     // T+51
    n_vec++; if (o_frame !== 1'b1) begin n_err++; $display("FAIL busy_frame got %0b want 1", o_frame); end
    n_vec++; if (o_cells !== pat(5, mask)) begin n_err++; $display("FAIL busy_newcells got %h want %h", o_cells, pat(5, mask)); end
    cycles(3);
    n_vec++; if (frames - f0 !== 1) begin n_err++; $display("FAIL busy_count got %0d want 1", frames - f0); end
  endtask

  task automatic test_overrun();
    mask = 32'h00000003;
    f0 = frames;
    gen_pulse();                                   // T+1
    cycles(9);                                     // T+10
    i_generation_done = 1'b1;
    n_vec++; if (o_overrun !== 1'b0) begin n_err++; $display("FAIL ovr_pre got %0b want 0", o_overrun); end
    cycles(1);                                     // T+11
    i_generation_done = 1'b0;
    n_vec++; if (o_overrun !== 1'b1) begin n_err++; $display("FAIL ovr_pulse got %0b want 1", o_overrun); end
    cycles(1);                                     // T+12
    n_vec++; if (o_overrun !== 1'b0) begin n_err++; $display("FAIL ovr_width got %0b want 0", o_overrun); end
    cycles(23);                                    // T+35
    n_vec++; if (o_frame !== 1'b1) begin n_err++; $display("FAIL ovr_frame got %0b want 1", o_frame); end
    cycles(40);
    n_vec++; if (frames - f0 !== 1) begin n_err++; $display("FAIL ovr_count got %0d want 1", frames - f0); end
    n_vec++; if (o_cells !== pat(5, mask)) begin n_err++; $display("FAIL ovr_cells got %h want %h", o_cells, pat(5, mask)); end
  endtask

  task automatic test_enable_drop();
    mask = 32'h55555555;
    f0 = frames;
    gen_pulse();                                   // T+1
    cycles(19);                                    // T+20
    i_enable = 1'b0;
    i_generation_done = 1'b1;
    cycles(1);                                     // T+21
    i_enable = 1'b1;
    i_generation_done = 1'b0;
    n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL en_idle got %0b want 0", o_busy); end
    n_vec++; if (o_overrun !== 1'b0) begin n_err++; $display("FAIL en_no_overrun got %0b want 0", o_overrun); end
    cycles(40);
    n_vec++; if (frames - f0 !== 0) begin n_err++; $display("FAIL en_noframe got %0d want 0", frames - f0); end
    n_vec++; if (o_cells !== pat(5, 32'h3)) begin n_err++; $display("FAIL en_keep got %h want %h", o_cells, pat(5, 32'h3)); end
    n_vec++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL en_valid got %0b want 1", o_valid); end
    mask = 32'h77777777;
    gen_pulse();
    cycles(34);                                    // T+35
    n_vec++; if (o_frame !== 1'b1) begin n_err++; $display("FAIL en_reframe got %0b want 1", o_frame); end
    n_vec++; if (o_cells !== pat(5, mask)) begin n_err++; $display("FAIL en_recells got %h want %h", o_cells, pat(5, mask)); end
    cycles(3);
  endtask

  task automatic test_back_to_back();
    int want;
`ifdef SILIFE_SNAPSHOT_SKIP_UNCHANGED_EN
    want = 1;
`else
    want = 2;
`endif
    mask = 32'h99999999;
    f0 = frames;
    gen_pulse();
    cycles(40);
    gen_pulse();
    cycles(40);
    n_vec++; if (frames - f0 !== want) begin n_err++; $display("FAIL b2b_count got %0d want %0d", frames - f0, want); end
    n_vec++; if (o_cells !== pat(5, mask)) begin n_err++; $display("FAIL b2b_cells got %h want %h", o_cells, pat(5, mask)); end
    i_row_select = 5'd17; #1;
    n_vec++; if (o_cells !== pat(17, mask)) begin n_err++; $display("FAIL b2b_row17 got %h want %h", o_cells, pat(17, mask)); end
    i_row_select = 5'd5;
  endtask

  task automatic test_reset_in_swap();
    i_display_busy = 1'b1;
    gen_pulse();                                   // T+1
    cycles(39);                                    // T+40
    n_vec++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL rsw_pending got %0b want 1", o_busy); end
    reset = 1'b1;
    cycles(1);                                     // T+41
    n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL rsw_valid got %0b want 0", o_valid); end
    n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL rsw_busy got %0b want 0", o_busy); end
    n_vec++; if (o_cells !== 32'h0) begin n_err++; $display("FAIL rsw_cells got %h want 0", o_cells); end
    n_vec++; if (o_frame !== 1'b0) begin n_err++; $display("FAIL rsw_frame got %0b want 0", o_frame); end
    reset = 1'b0;
    i_display_busy = 1'b0;
    cycles(2);
    // Same data as the pre-reset front bank; must still swap after reset.
    f0 = frames;
    gen_pulse();
    cycles(34);
    n_vec++; if (o_frame !== 1'b1) begin n_err++; $display("FAIL rsw_first_frame got %0b want 1", o_frame); end
    n_vec++; if (o_cells !== pat(5, mask)) begin n_err++; $display("FAIL rsw_cells2 got %h want %h", o_cells, pat(5, mask)); end
    cycles(2);
    n_vec++; if (frames - f0 !== 1) begin n_err++; $display("FAIL rsw_count got %0d want 1", frames - f0); end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_display_busy();
    test_overrun();
    test_enable_drop();
    test_back_to_back();
    test_reset_in_swap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
